fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 169 ++++++++++++++++
 tb/tb_fetch_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, instruction memory handshake, one-entry stall buffer and IF/ID register.
// Optional macro FETCH_PERF_CNT_EN adds FetchCount/StallCount performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] IMemAddr,
    output logic        IMemReq,
    input  logic        IMemReady,
    input  logic [31:0] IMemData,
    output logic [31:0] Instruction_ID,
    output logic [31:0] PCPlus4_ID,
    output logic        Valid_ID,
    output logic [5:0]  OP
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount
`endif
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic [31:0] instr_id_q, instr_id_d;
    logic [31:0] pc4_id_q, pc4_id_d;
    logic        vld_id_q, vld_id_d;
    logic        load_id;
    logic [31:0] br_tgt;
    logic [31:0] pc_inc;

    assign br_tgt = BranchTarget & ~32'h3;
    assign pc_inc = pc_q + 32'd4;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        buf_instr_d = buf_instr_q;
        buf_pc4_d   = buf_pc4_q;
        instr_id_d  = instr_id_q;
        pc4_id_d    = pc4_id_q;
        vld_id_d    = vld_id_q;
        load_id     = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (BranchTaken) begin
                    vld_id_d = 1'b0;
                    // An unanswered request cannot be withdrawn; remember the target and swallow its data.
                    if (IMemReady) begin
                        pc_d = br_tgt;
                    end else begin
                        tgt_d   = br_tgt;
                        state_d = S_DISCARD;
                    end
                end else if (IMemReady) begin
                    pc_d = pc_inc;
                    if (Stall) begin
                        buf_instr_d = IMemData;
                        buf_pc4_d   = pc_inc;
                        state_d     = S_HOLD;
                    end else begin
                        instr_id_d = IMemData;
                        pc4_id_d   = pc_inc;
                        vld_id_d   = 1'b1;
                        load_id    = 1'b1;
                    end
                end else if (!Stall) begin
                    vld_id_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (BranchTaken) begin
                    vld_id_d = 1'b0;
                    pc_d     = br_tgt;
                    state_d  = S_FETCH;
                end else if (!Stall) begin
                    instr_id_d = buf_instr_q;
                    pc4_id_d   = buf_pc4_q;
                    vld_id_d   = 1'b1;
                    load_id    = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_DISCARD: begin
                vld_id_d = 1'b0;
                if (BranchTaken) begin
                    tgt_d = br_tgt;
                    if (IMemReady) begin
                        pc_d    = br_tgt;
                        state_d = S_FETCH;
                    end
                end else if (IMemReady) begin
                    pc_d    = tgt_q;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            tgt_q       <= 32'h0;
            buf_instr_q <= 32'h0;
            buf_pc4_q   <= 32'h0;
            instr_id_q  <= 32'h0;
            pc4_id_q    <= 32'h0;
            vld_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            buf_instr_q <= buf_instr_d;
            buf_pc4_q   <= buf_pc4_d;
            instr_id_q  <= instr_id_d;
            pc4_id_q    <= pc4_id_d;
            vld_id_q    <= vld_id_d;
        end
    end

    assign IMemAddr       = pc_q;
    assign IMemReq        = (state_q != S_HOLD);
    assign Instruction_ID = vld_id_q ? instr_id_q : 32'h0;
    assign PCPlus4_ID     = pc4_id_q;
    assign Valid_ID       = vld_id_q;
    assign OP             = Instruction_ID[31:26];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = load_id ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
        stall_cnt_d = Stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign FetchCount = fetch_cnt_q;
    assign StallCount = stall_cnt_q;
`else
    logic unused_load;
    assign unused_load = load_id;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus a random phase, checked against a queue of expected IF/ID words.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall, BranchTaken, IMemReady;
    logic [31:0] BranchTarget, IMemData;
    logic [31:0] IMemAddr;
    logic        IMemReq;
    logic [31:0] Instruction_ID, PCPlus4_ID;
    logic        Valid_ID;
    logic [5:0]  OP;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCount, StallCount;
`endif

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .Stall(Stall), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .IMemAddr(IMemAddr), .IMemReq(IMemReq),
        .IMemReady(IMemReady), .IMemData(IMemData), .Instruction_ID(Instruction_ID),
        .PCPlus4_ID(PCPlus4_ID), .Valid_ID(Valid_ID), .OP(OP)
`ifdef FETCH_PERF_CNT_EN
        , .FetchCount(FetchCount), .StallCount(StallCount)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] q_instr[$];
    logic [31:0] q_pc4[$];
    logic        discarding = 1'b0;
    int          exp_fetch  = 0;
    int          exp_stall  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:2], ~a[27:2]};
    endfunction

    // One clock: drive at negedge, memory answers for the presented address, then score after the edge.
    task automatic cycle(input logic st, input logic br, input logic rdy, input logic [31:0] tgt);
        logic        req_s;
        logic [31:0] addr_s, prev_instr, ei, ep;
        logic        prev_vld;
        @(negedge clk);
        Stall = st; BranchTaken = br; BranchTarget = tgt; IMemReady = rdy;
        IMemData   = mem_word(IMemAddr);
        req_s      = IMemReq;
        addr_s     = IMemAddr;
        prev_instr = Instruction_ID;
        prev_vld   = Valid_ID;
        if (st) exp_stall++;
        @(posedge clk);
        #1;
        if (br) begin
            q_instr.delete();
            q_pc4.delete();
            discarding = req_s && !rdy;
        end else if (req_s && rdy) begin
            if (discarding) discarding = 1'b0;
            else begin
                q_instr.push_back(mem_word(addr_s));
                q_pc4.push_back(addr_s + 32'd4);
            end
        end
        if (!st && !br && Valid_ID) begin
            if (q_instr.size() == 0) begin
                check("sb_underflow", 32'd0, 32'd1);
            end else begin
                ei = q_instr.pop_front();
                ep = q_pc4.pop_front();
                check("sb_instr", Instruction_ID, ei);
                check("sb_pc4", PCPlus4_ID, ep);
                check("sb_op", {26'd0, OP}, {26'd0, ei[31:26]});
                exp_fetch++;
            end
        end
        if (st && !br) begin
            check("stall_hold_vld", {31'd0, Valid_ID}, {31'd0, prev_vld});
            check("stall_hold_instr", Instruction_ID, prev_instr);
        end
        if (br) check("branch_kill", {31'd0, Valid_ID}, 32'd0);
        if (!Valid_ID) check("id_zero", Instruction_ID, 32'h0);
    endtask

    initial begin
        logic [31:0] saved;
        reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'h0;
        IMemReady = 1'b0; IMemData = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", {31'd0, Valid_ID}, 32'd0);
        check("rst_instr", Instruction_ID, 32'h0);
        check("rst_pc4", PCPlus4_ID, 32'h0);
        check("rst_addr", IMemAddr, RESET_PC);
        @(negedge clk);
        reset = 1'b0;
        check("rst_req", {31'd0, IMemReq}, 32'd1);

        // Zero-wait memory streams one instruction per cycle.
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        check("zw_addr1", IMemAddr, 32'h0040_0004);
        check("zw_vld1", {31'd0, Valid_ID}, 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        check("zw_addr2", IMemAddr, 32'h0040_0008);
        check("zw_vld2", {31'd0, Valid_ID}, 32'd1);

        // Memory waits three cycles.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            check("wait_addr", IMemAddr, 32'h0040_0008);
            check("wait_req", {31'd0, IMemReq}, 32'd1);
            check("wait_vld", {31'd0, Valid_ID}, 32'd0);
        end
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        check("wait_done_vld", {31'd0, Valid_ID}, 32'd1);
        check("wait_done_addr", IMemAddr, 32'h0040_000C);

        // Stall while a word returns: parked, then delivered after release.
        saved = Instruction_ID;
        cycle(1'b1, 1'b0, 1'b1, 32'h0);
        check("hold_req0", {31'd0, IMemReq}, 32'd0);
        check("hold_instr", Instruction_ID, saved);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("hold_req1", {31'd0, IMemReq}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check("unpark_vld", {31'd0, Valid_ID}, 32'd1);
        check("unpark_instr", Instruction_ID, mem_word(32'h0040_000C));
        check("unpark_req", {31'd0, IMemReq}, 32'd1);
        check("unpark_addr", IMemAddr, 32'h0040_0010);

        // Branch during an outstanding fetch.
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0040_0103);
        check("disc_addr_keep", IMemAddr, 32'h0040_0010);
        check("disc_req", {31'd0, IMemReq}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check("disc_addr_keep2", IMemAddr, 32'h0040_0010);
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        check("disc_target", IMemAddr, 32'h0040_0100);
        check("disc_vld", {31'd0, Valid_ID}, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        check("disc_next_vld", {31'd0, Valid_ID}, 32'd1);

        // A second branch during discard replaces the target.
        cycle(1'b0, 1'b1, 1'b0, 32'h0040_0200);
        cycle(1'b0, 1'b1, 1'b0, 32'h0040_0208);
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        check("retarget_addr", IMemAddr, 32'h0040_0208);

        // Branch overrides stall and coinciding ready.
        cycle(1'b1, 1'b1, 1'b1, 32'h0040_0300);
        check("br_stall_addr", IMemAddr, 32'h0040_0300);
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        check("br_stall_pc4", PCPlus4_ID, 32'h0040_0304);

        // PC wraps at 2^32.
        cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFD);
        check("wrap_pre_addr", IMemAddr, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        check("wrap_pc4", PCPlus4_ID, 32'h0);
        check("wrap_addr", IMemAddr, 32'h0);

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 2) != 0, $urandom);
        end

        // Reset pulse in the middle of a pending request.
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check("pre_rst_req", {31'd0, IMemReq}, 32'd1);
        @(negedge clk);
        IMemReady = 1'b0; Stall = 1'b0; BranchTaken = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_vld", {31'd0, Valid_ID}, 32'd0);
        check("mid_rst_instr", Instruction_ID, 32'h0);
        check("mid_rst_pc4", PCPlus4_ID, 32'h0);
        check("mid_rst_addr", IMemAddr, RESET_PC);
`ifdef FETCH_PERF_CNT_EN
        check("mid_rst_fcnt", FetchCount, 32'h0);
        check("mid_rst_scnt", StallCount, 32'h0);
`endif
        @(negedge clk);
        reset = 1'b0;
        q_instr.delete();
        q_pc4.delete();
        discarding = 1'b0;
        exp_fetch  = 0;
        exp_stall  = 0;
        check("post_rst_addr", IMemAddr, RESET_PC);
        check("post_rst_req", {31'd0, IMemReq}, 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        check("post_rst_vld", {31'd0, Valid_ID}, 32'd1);
        check("post_rst_pc4", PCPlus4_ID, RESET_PC + 32'd4);
        for (int i = 0; i < 40; i++) begin
            cycle($urandom_range(0, 2) == 0, 1'b0, $urandom_range(0, 1) == 1, 32'h0);
        end
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count", FetchCount, exp_fetch);
        check("stall_count", StallCount, exp_stall);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
